// File: rtl/rr_arb_mux_pkg.sv
// rtl/rr_arb_mux_pkg.sv - shared constants and sizing helpers for the arbitrated mux family
//
// Purpose : arbitration mode constants and index-width helpers, shared by the
//           arbitrated mux, its interface and its priority picker.
// Ports   : none (package).

package rr_arb_mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Select/index width. Never below one bit so a single-channel build still
    // has a legal out_sel/force_sel vector.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - handshake bundle between N sources, the arbitrated mux and one sink
//
// Purpose : groups the per-channel inputs, the force controls and the registered
//           output handshake of rr_arb_mux.
// Signals : in_valid/in_data/in_ready  N_CH source channels (channel i at [i*WIDTH +: WIDTH])
//           force_en/force_sel         software-forced channel select
//           out_valid/out_data/out_sel registered output word and its source index
//           out_ready                  sink accept
// Modports: slave  - the mux itself
//           master - the environment driving sources and sink

interface rr_arb_mux_if
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_CH  = 4
);
    localparam int SEL_W = sel_width(N_CH);

    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  force_en;
    logic [SEL_W-1:0]      force_sel;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;

    modport slave (
        input  in_valid, in_data, force_en, force_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, force_en, force_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotating priority encoder
//
// Purpose : picks the first set request at or after index 'start', wrapping
//           from N_CH-1 back to 0.
// Ports   : req   [N_CH]  request vector
//           start [SEL_W] first index to consider (must be < N_CH)
//           grant [N_CH]  one-hot winner, zero when no request
//           idx   [SEL_W] encoded winner, zero when no request

module rr_priority_pick
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] start,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] idx
);

    // The request vector is laid out twice; positions below 'start' in the
    // lower copy are masked, so a plain lowest-bit search over the doubled
    // vector gives the wrap-around order without any rotate logic.
    logic [2*N_CH-1:0] dbl;
    logic              found;

    always_comb begin
        dbl   = {req, req};
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 2*N_CH; i++) begin
            if (!found && dbl[i] && (i >= int'(start))) begin
                found = 1'b1;
                idx   = SEL_W'(i % N_CH);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int j = 0; j < N_CH; j++) begin
            grant[j] = found && (idx == SEL_W'(j));
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel valid/ready mux with round-robin, fixed or forced select
//
// Purpose : arbitrates N_CH sources onto one registered output word.
//           ARB_MODE = ARB_RR rotates priority after each grant; ARB_FIXED
//           always favours the lowest index; force_en overrides both.
// Ports   : clk    rising-edge clock
//           reset  asynchronous, active-high
//           bus    rr_arb_mux_if.slave (sources, force controls, output handshake)

module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_CH     = 4,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic          clk,
    input  logic          reset,
    rr_arb_mux_if.slave   bus
);

    localparam int SEL_W = sel_width(N_CH);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] start;
    logic             load;
    logic [N_CH-1:0]  pick_grant;
    logic [SEL_W-1:0] pick_idx;
    logic [N_CH-1:0]  force_grant;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] gsel;
    logic             take;
    logic [WIDTH-1:0] sel_data;

    // Output register can take a word when empty or being drained this cycle.
    assign load  = ~bus.out_valid | bus.out_ready;
    assign start = (ARB_MODE == ARB_FIXED) ? '0 : ptr;

    rr_priority_pick #(
        .N_CH (N_CH)
    ) u_pick (
        .req   (bus.in_valid),
        .start (start),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // An out-of-range force_sel matches no channel, so it yields no grant.
    always_comb begin
        force_grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(bus.force_sel) == i) begin
                force_grant[i] = bus.in_valid[i];
            end
        end
    end

    always_comb begin
        grant = '0;
        gsel  = '0;
        if (load && !reset) begin
            if (bus.force_en) begin
                grant = force_grant;
                gsel  = bus.force_sel;
            end else begin
                grant = pick_grant;
                gsel  = pick_idx;
            end
        end
    end

    assign take         = |grant;
    assign bus.in_ready = grant;

    // One-hot AND-OR select keeps the data path free of a variable part-select.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
        end else if (load) begin
            bus.out_valid <= take;
            if (take) begin
                bus.out_data <= sel_data;
                bus.out_sel  <= gsel;
            end
        end
    end

    // Pointer moves only on arbitrated round-robin grants; forced grants
    // leave the rotation where it was.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (take && !bus.force_en && (ARB_MODE == ARB_RR)) begin
            ptr <= (gsel == SEL_W'(N_CH - 1)) ? '0 : gsel + 1'b1;
        end
    end

endmodule
